// File: rtl/gcd_pkg.sv
// Shared definitions for the Stein GCD responder: FSM states, default width
// and the worst-case latency bound used by the block and its bench.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STRIP  = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int GCD_WIDTH_DEFAULT = 8;

    // Cycles from the accept edge to the first cycle with out_valid high.
    function automatic int max_lat(input int w);
        return 4 * w + 3;
    endfunction

endpackage

// File: rtl/gcd_reduce_step.sv
// One binary-GCD reduction step on an odd/even operand pair. Purely
// combinational so the FSM only decides when to apply the step.
module gcd_reduce_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] x_next,
    output logic [WIDTH-1:0] y_next,
    output logic             eq
);

    // Priority: halve an even x, else halve an even y, else (both odd)
    // finish on equality or subtract the smaller from the larger.
    always_comb begin
        x_next = x;
        y_next = y;
        eq     = 1'b0;
        if (!x[0]) begin
            x_next = x >> 1;
        end else if (!y[0]) begin
            y_next = y >> 1;
        end else if (x == y) begin
            eq = 1'b1;
        end else if (x > y) begin
            x_next = x - y;
        end else begin
            y_next = y - x;
        end
    end

endmodule

// File: rtl/gcd_stein_hs.sv
// Sequential binary (Stein) GCD with valid/ready handshakes on both sides.
// One request in flight; one shift or subtract per clock.
module gcd_stein_hs
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEFAULT,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] x_step;
    logic [WIDTH-1:0] y_step;
    logic             step_eq;

    gcd_reduce_step #(.WIDTH(WIDTH)) u_step (
        .x      (x),
        .y      (y),
        .x_next (x_step),
        .y_next (y_step),
        .eq     (step_eq)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == STRIP) || (state == REDUCE);

    // Control FSM and operand datapath; the result register holds through
    // any amount of backpressure in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            x      <= '0;
            y      <= '0;
            k      <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x <= a;
                        y <= b;
                        k <= '0;
                        // A zero operand makes the other operand the answer.
                        if ((a == '0) || (b == '0)) begin
                            result <= a | b;
                            state  <= DONE;
                        end else begin
                            state  <= STRIP;
                        end
                    end
                end
                STRIP: begin
                    // Pull out the common power of two, remembered in k.
                    if (!x[0] && !y[0]) begin
                        x <= x >> 1;
                        y <= y >> 1;
                        k <= k + KW'(1);
                    end else begin
                        state <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (step_eq) begin
                        // gcd <= min(a, b), so restoring 2^k cannot overflow.
                        result <= x << k;
                        state  <= DONE;
                    end else begin
                        x <= x_step;
                        y <= y_step;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_stein_hs.sv
// Bench for gcd_stein_hs: directed and random requests, a Euclid reference
// model and a per-cycle monitor of the handshake and result behaviour.
module tb_gcd_stein_hs;
    import gcd_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    int checks = 0;
    int errors = 0;

    gcd_stein_hs #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input bit ok, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: Euclid's algorithm, independent of the binary method.
    function automatic int egcd(input int p, input int q);
        int t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Monitor state
    bit         inflight = 0;
    bit         seen = 0;
    bit         hold_exp = 0;
    bit         after_consume = 0;
    int         mlat = 0;
    int         exp_res = 0;
    logic [W-1:0] prev_res = '0;

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", out_valid == 1'b0, int'(out_valid), 0);
            chk("rst_result", result == '0, int'(result), 0);
            chk("rst_busy", busy == 1'b0, int'(busy), 0);
            chk("rst_in_ready", in_ready == 1'b1, int'(in_ready), 1);
            inflight      = 0;
            seen          = 0;
            hold_exp      = 0;
            after_consume = 0;
        end else begin
            if (after_consume) begin
                chk("post_consume_in_ready", in_ready == 1'b1, int'(in_ready), 1);
                chk("post_consume_out_valid", out_valid == 1'b0, int'(out_valid), 0);
            end
            if (hold_exp) begin
                chk("hold_out_valid", out_valid == 1'b1, int'(out_valid), 1);
                chk("hold_result", result == prev_res, int'(result), int'(prev_res));
            end
            if (inflight) begin
                mlat++;
                chk("busy_in_ready", in_ready == 1'b0, int'(in_ready), 0);
                if (out_valid) begin
                    if (!seen) begin
                        chk("mon_result", int'(result) == exp_res, int'(result), exp_res);
                        chk("mon_latency", mlat >= 1 && mlat <= max_lat(W), mlat, max_lat(W));
                        seen = 1;
                    end
                end else begin
                    chk("mon_busy", busy == 1'b1, int'(busy), 1);
                end
            end else begin
                chk("idle_out_valid", out_valid == 1'b0, int'(out_valid), 0);
                chk("idle_busy", busy == 1'b0, int'(busy), 0);
            end
            hold_exp      = out_valid && !out_ready;
            prev_res      = result;
            after_consume = out_valid && out_ready;
            if (after_consume) inflight = 0;
            if (in_valid && in_ready) begin
                inflight = 1;
                seen     = 0;
                mlat     = 0;
                exp_res  = egcd(int'(a), int'(b));
            end
        end
    end

    // Issue one request, wait for the result, optionally backpressure, consume.
    task automatic run_req(input logic [W-1:0] va, input logic [W-1:0] vb, input int hold,
                           output logic [W-1:0] r, output int lat);
        int n;
        @(posedge clk);
        #1;
        a = va;
        b = vb;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 1'b0, n, 50);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 200);
        if (!out_valid) chk("result_timeout", 1'b0, lat, max_lat(W));
        r = result;
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            chk("bp_out_valid", out_valid == 1'b1, int'(out_valid), 1);
            chk("bp_result", result == r, int'(result), int'(r));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        int           exp;
        int           lat_min;
        int           lat_max;
    } vec_t;

    initial begin
        logic [W-1:0] r;
        int           lat;
        vec_t         vecs[10];

        vecs[0] = '{8'd1,   8'd1,   1,   3, 3};
        vecs[1] = '{8'd12,  8'd8,   4,   3, max_lat(W)};
        vecs[2] = '{8'd10,  8'd15,  5,   3, max_lat(W)};
        vecs[3] = '{8'd48,  8'd180, 12,  3, max_lat(W)};
        vecs[4] = '{8'd10,  8'd5,   5,   3, max_lat(W)};
        vecs[5] = '{8'd0,   8'd7,   7,   1, 1};
        vecs[6] = '{8'd0,   8'd0,   0,   1, 1};
        vecs[7] = '{8'd255, 8'd0,   255, 1, 1};
        vecs[8] = '{8'd255, 8'd1,   1,   3, 35};
        vecs[9] = '{8'd128, 8'd255, 1,   3, 35};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        // Pin the reference model with hand-computed values.
        chk("model_48_180", egcd(48, 180) == 12, egcd(48, 180), 12);
        chk("model_0_7", egcd(0, 7) == 7, egcd(0, 7), 7);
        chk("model_0_0", egcd(0, 0) == 0, egcd(0, 0), 0);

        #3;
        chk("reset_out_valid", out_valid == 1'b0, int'(out_valid), 0);
        chk("reset_result", result == '0, int'(result), 0);
        chk("reset_in_ready", in_ready == 1'b1, int'(in_ready), 1);
        chk("reset_busy", busy == 1'b0, int'(busy), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_req(vecs[i].va, vecs[i].vb, 0, r, lat);
            chk($sformatf("res_%0d_%0d", vecs[i].va, vecs[i].vb), int'(r) == vecs[i].exp,
                int'(r), vecs[i].exp);
            chk($sformatf("lat_%0d_%0d", vecs[i].va, vecs[i].vb),
                lat >= vecs[i].lat_min && lat <= vecs[i].lat_max, lat, vecs[i].lat_max);
        end

        // Backpressure: result must stay put for 10 cycles of out_ready low.
        run_req(8'd12, 8'd8, 10, r, lat);
        chk("bp_12_8", int'(r) == 4, int'(r), 4);

        // Asynchronous reset in the middle of (255,1).
        @(posedge clk);
        #1;
        a = 8'd255;
        b = 8'd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_busy", busy == 1'b1, int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid == 1'b0, int'(out_valid), 0);
        chk("midrst_result", result == '0, int'(result), 0);
        chk("midrst_busy", busy == 1'b0, int'(busy), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_req(8'd12, 8'd8, 0, r, lat);
        chk("after_rst_12_8", int'(r) == 4, int'(r), 4);
        chk("after_rst_lat", lat >= 3 && lat <= max_lat(W), lat, max_lat(W));

        // Random pairs against the Euclid model.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            run_req(ra, rb, 0, r, lat);
            chk("rand_result", int'(r) == egcd(int'(ra), int'(rb)), int'(r), egcd(int'(ra), int'(rb)));
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
